clint: RTL

Core-local interruptor and the responder end of the bus CLINT port. It decodes read and write requests that the bus has already range-checked and offset-rebased. It holds msip, the 64-bit mtimecmp and the free-running 64-bit mtime. It drives the machine software interrupt and the machine timer interrupt to the CSR/interrupt logic.

---
 rtl/clint.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/clint.sv
// Core-local interruptor: msip, 64-bit mtimecmp and free-running mtime behind the bus CLINT port.
// Optional CLINT_EXT_RTC_TICK_EN: mtime advances on synchronized rtc_tick rising edges instead of the prescaler.
module clint #(
  parameter int unsigned TICK_DIV       = 1,
  parameter logic [63:0] MTIME_RESET    = 64'd0,
  parameter int          ADDR_WIDTH     = 16,
  parameter int          SIZE_WIDTH     = 3,
  parameter int          REG_DATA_WIDTH = 32,
  parameter int          BUS_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     bus_clint_read_addr,
  input  logic [ADDR_WIDTH-1:0]     bus_clint_write_addr,
  input  logic [SIZE_WIDTH-1:0]     bus_clint_read_size,
  input  logic [SIZE_WIDTH-1:0]     bus_clint_write_size,
  input  logic [REG_DATA_WIDTH-1:0] bus_clint_data,
  input  logic                      bus_clint_rd,
  input  logic                      bus_clint_wr,
`ifdef CLINT_EXT_RTC_TICK_EN
  input  logic                      rtc_tick,
`endif
  output logic [BUS_DATA_WIDTH-1:0] clint_bus_data,
  output logic                      msip_irq,
  output logic                      mtip_irq
);

  typedef enum logic [2:0] {
    SEL_NONE, SEL_MSIP, SEL_CMP_LO, SEL_CMP_HI, SEL_TIME_LO, SEL_TIME_HI
  } sel_e;

  function automatic sel_e decode(input logic [13:0] w);
    case (w)
      14'h0000: return SEL_MSIP;
      14'h1000: return SEL_CMP_LO;
      14'h1001: return SEL_CMP_HI;
      14'h2FFE: return SEL_TIME_LO;
      14'h2FFF: return SEL_TIME_HI;
      default:  return SEL_NONE;
    endcase
  endfunction

  // Byte lanes past bit 31 are dropped rather than wrapping into the next word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] off,
                                        input logic [SIZE_WIDTH-1:0] size, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (k < int'(size) && int'(off) + k < 4) r[(int'(off) + k)*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [SIZE_WIDTH-1:0] size);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      if (k < int'(size) && int'(off) + k < 4) r[k*8 +: 8] = w[(int'(off) + k)*8 +: 8];
    return r;
  endfunction

  logic                      msip_q, msip_d;
  logic [63:0]               cmp_q, cmp_d;
  logic [63:0]               time_q, time_d;
  logic                      mtip_q;
  logic [BUS_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      tick;

  sel_e        rsel, wsel;
  logic [31:0] rword, wold, wnew;

  assign rsel = decode(bus_clint_read_addr[15:2]);
  assign wsel = decode(bus_clint_write_addr[15:2]);

  always_comb begin
    rword = '0;
    case (rsel)
      SEL_MSIP:    rword = {31'd0, msip_q};
      SEL_CMP_LO:  rword = cmp_q[31:0];
      SEL_CMP_HI:  rword = cmp_q[63:32];
      SEL_TIME_LO: rword = time_q[31:0];
      SEL_TIME_HI: rword = time_q[63:32];
      default:     rword = '0;
    endcase
  end

  always_comb begin
    wold = '0;
    case (wsel)
      SEL_MSIP:    wold = {31'd0, msip_q};
      SEL_CMP_LO:  wold = cmp_q[31:0];
      SEL_CMP_HI:  wold = cmp_q[63:32];
      SEL_TIME_LO: wold = time_q[31:0];
      SEL_TIME_HI: wold = time_q[63:32];
      default:     wold = '0;
    endcase
  end

  assign wnew = merge(wold, bus_clint_write_addr[1:0], bus_clint_write_size, bus_clint_data[31:0]);

  always_comb begin
    rdata_d = rdata_q;
    if (bus_clint_rd)
      rdata_d = BUS_DATA_WIDTH'(extract(rword, bus_clint_read_addr[1:0], bus_clint_read_size));
  end

  // A write to one mtime half suppresses that cycle's tick: the other half holds, no carry.
  always_comb begin
    msip_d = msip_q;
    cmp_d  = cmp_q;
    time_d = tick ? time_q + 64'd1 : time_q;
    if (bus_clint_wr) begin
      case (wsel)
        SEL_MSIP:    msip_d = wnew[0];
        SEL_CMP_LO:  cmp_d  = {cmp_q[63:32], wnew};
        SEL_CMP_HI:  cmp_d  = {wnew, cmp_q[31:0]};
        SEL_TIME_LO: time_d = {time_q[63:32], wnew};
        SEL_TIME_HI: time_d = {wnew, time_q[31:0]};
        default: ;
      endcase
    end
  end

`ifdef CLINT_EXT_RTC_TICK_EN
  // [0],[1] synchronize; [2] holds the previous synchronized level for edge detect.
  logic [2:0] rtc_q;
  always_ff @(posedge clk) begin
    if (rst) rtc_q <= '0;
    else     rtc_q <= {rtc_q[1:0], rtc_tick};
  end
  assign tick = rtc_q[1] & ~rtc_q[2];
`else
  logic [31:0] presc_q;
  assign tick = (presc_q == TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst)       presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q  <= 1'b0;
      cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      time_q  <= MTIME_RESET;
      mtip_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      msip_q  <= msip_d;
      cmp_q   <= cmp_d;
      time_q  <= time_d;
      mtip_q  <= (time_q >= cmp_q);
      rdata_q <= rdata_d;
    end
  end

  assign clint_bus_data = rdata_q;
  assign msip_irq       = msip_q;
  assign mtip_irq       = mtip_q;

endmodule
